// File: rtl/host_axim_bridge.sv
// -----------------------------------------------------------------------------
// host_axim_bridge
//   Upstream master on the host_axim AXI3 bus. Turns single commands from the
//   host transactor into one AXI3 INCR burst of 64-bit beats, streams write
//   data in / read data out, and reports one completion status per command.
//   Only one transaction is in flight; a watchdog aborts a stalled transfer.
//
// Ports
//   dut_clock, dut_reset_n        clock, asynchronous active-low reset
//   cmd_*                         command handshake (write/addr/len/id)
//   wr_*                          host write-data stream (passed to W)
//   rd_*                          host read-data stream (fed from R)
//   done_valid/resp/id            one-cycle completion pulse with status
//   timeout_err, id_err           sticky error flags (cleared by reset only)
//   host_axim_Aw_* / W_* / B_*    AXI3 write address, data, response channels
//   host_axim_Ar_* / R_*          AXI3 read address and data channels
// -----------------------------------------------------------------------------
module host_axim_bridge #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ID_W        = 9,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                dut_clock,
  input  logic                dut_reset_n,
  // command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [ID_W-1:0]     cmd_id,
  // write data from host
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  // read data to host
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic [1:0]          rd_resp,
  // completion and errors
  output logic                done_valid,
  output logic [1:0]          done_resp,
  output logic [ID_W-1:0]     done_id,
  output logic                timeout_err,
  output logic                id_err,
  // AXI3 write address
  output logic [ADDR_W-1:0]   host_axim_Aw_Addr,
  output logic [ID_W-1:0]     host_axim_Aw_Id,
  output logic [3:0]          host_axim_Aw_Len,
  output logic [2:0]          host_axim_Aw_Size,
  output logic [1:0]          host_axim_Aw_Burst,
  output logic [1:0]          host_axim_Aw_Lock,
  output logic [3:0]          host_axim_Aw_Cache,
  output logic [2:0]          host_axim_Aw_Prot,
  output logic                host_axim_Aw_Valid,
  input  logic                host_axim_Aw_Ready,
  // AXI3 write data
  output logic [DATA_W-1:0]   host_axim_W_Data,
  output logic [DATA_W/8-1:0] host_axim_W_Strb,
  output logic [ID_W-1:0]     host_axim_W_Id,
  output logic                host_axim_W_Last,
  output logic                host_axim_W_Valid,
  input  logic                host_axim_W_Ready,
  // AXI3 write response
  input  logic [ID_W-1:0]     host_axim_B_Id,
  input  logic [1:0]          host_axim_B_Resp,
  input  logic                host_axim_B_Valid,
  output logic                host_axim_B_Ready,
  // AXI3 read address
  output logic [ADDR_W-1:0]   host_axim_Ar_Addr,
  output logic [ID_W-1:0]     host_axim_Ar_Id,
  output logic [3:0]          host_axim_Ar_Len,
  output logic [2:0]          host_axim_Ar_Size,
  output logic [1:0]          host_axim_Ar_Burst,
  output logic [1:0]          host_axim_Ar_Lock,
  output logic [3:0]          host_axim_Ar_Cache,
  output logic [2:0]          host_axim_Ar_Prot,
  output logic                host_axim_Ar_Valid,
  input  logic                host_axim_Ar_Ready,
  // AXI3 read data
  input  logic [DATA_W-1:0]   host_axim_R_Data,
  input  logic [ID_W-1:0]     host_axim_R_Id,
  input  logic [1:0]          host_axim_R_Resp,
  input  logic                host_axim_R_Last,
  input  logic                host_axim_R_Valid,
  output logic                host_axim_R_Ready
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic [3:0]        r_len;
  logic [3:0]        r_beat;
  logic [1:0]        r_resp;
  logic [WD_W-1:0]   r_wdog;
  logic              r_timeout_err;
  logic              r_id_err;

  logic [9:0]        w_end_beat;
  logic              w_cross;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_any_hs;
  logic              w_bus;
  logic              w_wd_expire;
  logic              w_unused_addr_lsb;

  // Low address bits are ignored: bursts are always 8-byte aligned.
  assign w_unused_addr_lsb = ^cmd_addr[2:0];

  // Beat index (8-byte units within the 4KB page) one past the last beat;
  // anything beyond 512 spills into the next page.
  assign w_end_beat = {1'b0, cmd_addr[11:3]} + {6'b0, cmd_len} + 10'd1;
  assign w_cross    = (w_end_beat > 10'd512);

  assign w_aw_hs  = (r_state == WR_ADDR) && host_axim_Aw_Ready;
  assign w_w_hs   = (r_state == WR_DATA) && wr_valid && host_axim_W_Ready;
  assign w_b_hs   = (r_state == WR_RESP) && host_axim_B_Valid;
  assign w_ar_hs  = (r_state == RD_ADDR) && host_axim_Ar_Ready;
  assign w_r_hs   = (r_state == RD_DATA) && host_axim_R_Valid && rd_ready;
  assign w_any_hs = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;

  assign w_bus = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                 (r_state == WR_RESP) || (r_state == RD_ADDR) ||
                 (r_state == RD_DATA);

  // A handshake on the expiring cycle still counts as progress.
  assign w_wd_expire = w_bus && !w_any_hs &&
                       (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  // Fixed AXI3 attributes and registered command fields.
  assign host_axim_Aw_Addr  = r_addr;
  assign host_axim_Aw_Id    = r_id;
  assign host_axim_Aw_Len   = r_len;
  assign host_axim_Aw_Size  = 3'b011;
  assign host_axim_Aw_Burst = 2'b01;
  assign host_axim_Aw_Lock  = 2'b00;
  assign host_axim_Aw_Cache = 4'b0011;
  assign host_axim_Aw_Prot  = 3'b000;

  assign host_axim_Ar_Addr  = r_addr;
  assign host_axim_Ar_Id    = r_id;
  assign host_axim_Ar_Len   = r_len;
  assign host_axim_Ar_Size  = 3'b011;
  assign host_axim_Ar_Burst = 2'b01;
  assign host_axim_Ar_Lock  = 2'b00;
  assign host_axim_Ar_Cache = 4'b0011;
  assign host_axim_Ar_Prot  = 3'b000;

  assign host_axim_W_Data = wr_data;
  assign host_axim_W_Strb = wr_strb;
  assign host_axim_W_Id   = r_id;

  assign rd_data = host_axim_R_Data;
  assign rd_last = host_axim_R_Last;
  assign rd_resp = host_axim_R_Resp;

  assign done_resp   = r_resp;
  assign done_id     = r_id;
  assign timeout_err = r_timeout_err;
  assign id_err      = r_id_err;

  // State register; reset abandons any bus activity immediately.
  always_ff @(posedge dut_clock or negedge dut_reset_n) begin
    if (!dut_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded handshake outputs. All valids/readies are
  // decoded from the state, so a watchdog abort drops them on entry to DONE.
  always_comb begin
    w_next             = r_state;
    cmd_ready          = 1'b0;
    host_axim_Aw_Valid = 1'b0;
    host_axim_W_Valid  = 1'b0;
    host_axim_W_Last   = 1'b0;
    wr_ready           = 1'b0;
    host_axim_B_Ready  = 1'b0;
    host_axim_Ar_Valid = 1'b0;
    host_axim_R_Ready  = 1'b0;
    rd_valid           = 1'b0;
    done_valid         = 1'b0;

    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_cross)        w_next = DONE;
          else if (cmd_write) w_next = WR_ADDR;
          else                w_next = RD_ADDR;
        end
      end
      WR_ADDR: begin
        host_axim_Aw_Valid = 1'b1;
        if (w_aw_hs) w_next = WR_DATA;
      end
      WR_DATA: begin
        host_axim_W_Valid = wr_valid;
        wr_ready          = host_axim_W_Ready;
        host_axim_W_Last  = (r_beat == r_len);
        if (w_w_hs && (r_beat == r_len)) w_next = WR_RESP;
      end
      WR_RESP: begin
        host_axim_B_Ready = 1'b1;
        if (w_b_hs) w_next = DONE;
      end
      RD_ADDR: begin
        host_axim_Ar_Valid = 1'b1;
        if (w_ar_hs) w_next = RD_DATA;
      end
      RD_DATA: begin
        rd_valid          = host_axim_R_Valid;
        host_axim_R_Ready = rd_ready;
        if (w_r_hs && host_axim_R_Last) w_next = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase

    if (w_wd_expire) w_next = DONE;
  end

  // Command latch, beat counter, status accumulation and watchdog.
  always_ff @(posedge dut_clock or negedge dut_reset_n) begin
    if (!dut_reset_n) begin
      r_addr        <= '0;
      r_id          <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_resp        <= '0;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
      r_id_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr <= {cmd_addr[ADDR_W-1:3], 3'b000};
            r_id   <= cmd_id;
            r_len  <= cmd_len;
            r_beat <= '0;
            r_resp <= w_cross ? 2'b10 : 2'b00;
          end
        end
        WR_DATA: begin
          if (w_w_hs) r_beat <= r_beat + 4'd1;
        end
        WR_RESP: begin
          if (w_b_hs) begin
            if (host_axim_B_Id != r_id) begin
              r_id_err <= 1'b1;
              r_resp   <= 2'b10;
            end else begin
              r_resp <= host_axim_B_Resp;
            end
          end
        end
        RD_DATA: begin
          if (w_r_hs) begin
            r_beat <= r_beat + 4'd1;
            // An ID mismatch overrides; otherwise keep the first error seen.
            if (host_axim_R_Id != r_id) begin
              r_id_err <= 1'b1;
              r_resp   <= 2'b10;
            end else if (r_resp == 2'b00) begin
              r_resp <= host_axim_R_Resp;
            end
            if (host_axim_R_Last != (r_beat == r_len)) r_id_err <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_wd_expire) begin
        r_timeout_err <= 1'b1;
        r_resp        <= 2'b11;
      end

      if (!w_bus || w_any_hs || (w_next != r_state)) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + WD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_host_axim_bridge.sv
// -----------------------------------------------------------------------------
// tb_host_axim_bridge
//   Directed bench for host_axim_bridge. The bench itself plays both the host
//   transactor and the AXI3 slave, one cycle at a time. Inputs change 1ns
//   after the rising edge and outputs are checked 2ns after it.
// -----------------------------------------------------------------------------
module tb_host_axim_bridge;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [8:0]  cmd_id;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic [1:0]  rd_resp;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [8:0]  done_id;
  logic        timeout_err, id_err;

  logic [31:0] aw_addr, ar_addr;
  logic [8:0]  aw_id, ar_id;
  logic [3:0]  aw_len, ar_len, aw_cache, ar_cache;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst, aw_lock, ar_lock;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic [8:0]  w_id;
  logic        w_last, w_valid, w_ready;
  logic [8:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [63:0] r_data;
  logic [8:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n;

  host_axim_bridge #(
    .ADDR_W      (32),
    .DATA_W      (64),
    .ID_W        (9),
    .TIMEOUT_CYC (1024)
  ) dut (
    .dut_clock          (clk),
    .dut_reset_n        (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_addr           (cmd_addr),
    .cmd_len            (cmd_len),
    .cmd_id             (cmd_id),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_data            (wr_data),
    .wr_strb            (wr_strb),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_data            (rd_data),
    .rd_last            (rd_last),
    .rd_resp            (rd_resp),
    .done_valid         (done_valid),
    .done_resp          (done_resp),
    .done_id            (done_id),
    .timeout_err        (timeout_err),
    .id_err             (id_err),
    .host_axim_Aw_Addr  (aw_addr),
    .host_axim_Aw_Id    (aw_id),
    .host_axim_Aw_Len   (aw_len),
    .host_axim_Aw_Size  (aw_size),
    .host_axim_Aw_Burst (aw_burst),
    .host_axim_Aw_Lock  (aw_lock),
    .host_axim_Aw_Cache (aw_cache),
    .host_axim_Aw_Prot  (aw_prot),
    .host_axim_Aw_Valid (aw_valid),
    .host_axim_Aw_Ready (aw_ready),
    .host_axim_W_Data   (w_data),
    .host_axim_W_Strb   (w_strb),
    .host_axim_W_Id     (w_id),
    .host_axim_W_Last   (w_last),
    .host_axim_W_Valid  (w_valid),
    .host_axim_W_Ready  (w_ready),
    .host_axim_B_Id     (b_id),
    .host_axim_B_Resp   (b_resp),
    .host_axim_B_Valid  (b_valid),
    .host_axim_B_Ready  (b_ready),
    .host_axim_Ar_Addr  (ar_addr),
    .host_axim_Ar_Id    (ar_id),
    .host_axim_Ar_Len   (ar_len),
    .host_axim_Ar_Size  (ar_size),
    .host_axim_Ar_Burst (ar_burst),
    .host_axim_Ar_Lock  (ar_lock),
    .host_axim_Ar_Cache (ar_cache),
    .host_axim_Ar_Prot  (ar_prot),
    .host_axim_Ar_Valid (ar_valid),
    .host_axim_Ar_Ready (ar_ready),
    .host_axim_R_Data   (r_data),
    .host_axim_R_Id     (r_id),
    .host_axim_R_Resp   (r_resp),
    .host_axim_R_Last   (r_last),
    .host_axim_R_Valid  (r_valid),
    .host_axim_R_Ready  (r_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_id = '0; wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    rd_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; b_id = '0;
    b_resp = '0; b_valid = 1'b0; ar_ready = 1'b0; r_data = '0; r_id = '0;
    r_resp = '0; r_last = 1'b0; r_valid = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [3:0] len, input logic [8:0] id);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_len = len; cmd_id = id;
    settle();
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();

    // ---- reset state -----------------------------------------------------
    rst_n = 1'b0;
    step(); step();
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_flags", {timeout_err, id_err}, 0);
    chk("rst_aw_addr", aw_addr, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();

    // ---- write 0x100, len 3, id 0x055 -------------------------------------
    issue(1'b1, 32'h0000_0104, 4'd3, 9'h055);
    settle();
    chk("wr_aw_valid", aw_valid, 1);
    chk("wr_aw_addr", aw_addr, 32'h100);
    chk("wr_aw_len", aw_len, 3);
    chk("wr_aw_id", aw_id, 9'h055);
    chk("wr_aw_attr", {aw_size, aw_burst, aw_lock, aw_cache, aw_prot},
        {3'b011, 2'b01, 2'b00, 4'b0011, 3'b000});
    chk("wr_cmd_ready_busy", cmd_ready, 0);
    step();                                   // slave not ready yet
    aw_ready = 1'b1;
    step();                                   // AW handshake
    aw_ready = 1'b0;
    wr_strb  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 64'h11 * (i + 1);
      if (i == 1) begin
        w_ready = 1'b0;                       // slave stalls beat 2 once
        settle();
        chk("wr_stall_ready", wr_ready, 0);
        chk("wr_stall_valid", w_valid, 1);
        step();
      end
      w_ready = 1'b1;
      settle();
      if (i == 0) chk("wr_aw_dropped", aw_valid, 0);
      chk("wr_w_valid", w_valid, 1);
      chk("wr_w_data", w_data, 64'h11 * (i + 1));
      chk("wr_w_last", w_last, (i == 3));
      chk("wr_wr_ready", wr_ready, 1);
      chk("wr_w_id", w_id, 9'h055);
      step();
    end
    wr_valid = 1'b0; w_ready = 1'b0;
    b_valid = 1'b1; b_id = 9'h055; b_resp = 2'b00;
    settle();
    chk("wr_b_ready", b_ready, 1);
    chk("wr_w_valid_off", w_valid, 0);
    step();
    b_valid = 1'b0;
    settle();
    chk("wr_done_valid", done_valid, 1);
    chk("wr_done_resp", done_resp, 0);
    chk("wr_done_id", done_id, 9'h055);
    chk("wr_done_cmd_ready", cmd_ready, 0);
    step();
    chk("wr_done_pulse", done_valid, 0);

    // ---- read 0x100, len 3, id 0x0A3 --------------------------------------
    issue(1'b0, 32'h0000_0100, 4'd3, 9'h0A3);
    settle();
    chk("rd_ar_valid", ar_valid, 1);
    chk("rd_ar_addr", ar_addr, 32'h100);
    chk("rd_ar_len", ar_len, 3);
    chk("rd_aw_quiet", aw_valid, 0);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1; r_id = 9'h0A3; r_resp = 2'b00;
      r_data = 64'h11 * (i + 1); r_last = (i == 3); rd_ready = 1'b1;
      settle();
      chk("rd_valid", rd_valid, 1);
      chk("rd_r_ready", r_ready, 1);
      chk("rd_data", rd_data, 64'h11 * (i + 1));
      chk("rd_last", rd_last, (i == 3));
      step();
    end
    r_valid = 1'b0; r_last = 1'b0; rd_ready = 1'b0;
    settle();
    chk("rd_done_valid", done_valid, 1);
    chk("rd_done_resp", done_resp, 0);
    chk("rd_done_id", done_id, 9'h0A3);
    chk("rd_id_err", id_err, 0);
    step();

    // ---- 4KB crossing: 0xFF8 + 2 beats ------------------------------------
    issue(1'b1, 32'h0000_0FF8, 4'd1, 9'h007);
    settle();
    chk("x4k_aw_valid", aw_valid, 0);
    chk("x4k_ar_valid", ar_valid, 0);
    chk("x4k_done_valid", done_valid, 1);
    chk("x4k_done_resp", done_resp, 2'b10);
    step();
    chk("x4k_back_idle", cmd_ready, 1);

    // ---- watchdog: 0xFF0 + 2 beats ends exactly on the page, Aw stalls ----
    issue(1'b1, 32'h0000_0FF0, 4'd1, 9'h033);
    settle();
    chk("to_edge_aw_valid", aw_valid, 1);
    n = 0;
    while (aw_valid === 1'b1 && n < 2000) begin
      n++;
      step();
    end
    chk("to_aw_cycles", n, 1024);
    chk("to_aw_dropped", aw_valid, 0);
    chk("to_done_valid", done_valid, 1);
    chk("to_done_resp", done_resp, 2'b11);
    chk("to_timeout_err", timeout_err, 1);
    step();
    chk("to_back_idle", cmd_ready, 1);
    chk("to_sticky", timeout_err, 1);

    // ---- read 0x200 len 3 with SLVERR on beat 2, rd_ready toggling -------
    issue(1'b0, 32'h0000_0200, 4'd3, 9'h1FF);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1; r_id = 9'h1FF; r_data = 64'hA0 + i;
      r_resp = (i == 1) ? 2'b10 : 2'b00; r_last = (i == 3);
      rd_ready = 1'b0;
      settle();
      chk("se_hold_valid", rd_valid, 1);
      chk("se_hold_r_ready", r_ready, 0);
      chk("se_hold_data", rd_data, 64'hA0 + i);
      step();
      rd_ready = 1'b1;
      settle();
      chk("se_r_ready", r_ready, 1);
      chk("se_rd_data", rd_data, 64'hA0 + i);
      chk("se_rd_resp", rd_resp, (i == 1) ? 2 : 0);
      step();
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; rd_ready = 1'b0;
    settle();
    chk("se_done_valid", done_valid, 1);
    chk("se_done_resp", done_resp, 2'b10);
    chk("se_id_err", id_err, 0);
    step();

    // ---- write with B_Id mismatch -----------------------------------------
    issue(1'b1, 32'h0000_0400, 4'd0, 9'h011);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 64'h5A; w_ready = 1'b1;
    settle();
    chk("ide_w_last_single", w_last, 1);
    step();
    wr_valid = 1'b0; w_ready = 1'b0;
    b_valid = 1'b1; b_id = 9'h012; b_resp = 2'b00;
    step();
    b_valid = 1'b0;
    settle();
    chk("ide_done_resp", done_resp, 2'b10);
    chk("ide_id_err", id_err, 1);
    step();

    // ---- reset during WR_DATA beat 2 --------------------------------------
    issue(1'b1, 32'h0000_0300, 4'd3, 9'h044);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 64'h1; w_ready = 1'b1;
    step();
    wr_data = 64'h2;
    settle();
    chk("mr_beat2_valid", w_valid, 1);
    rst_n = 1'b0;
    settle();
    chk("mr_w_valid", w_valid, 0);
    chk("mr_wr_ready", wr_ready, 0);
    chk("mr_aw_valid", aw_valid, 0);
    chk("mr_b_ready", b_ready, 0);
    chk("mr_flags_clear", {timeout_err, id_err}, 0);
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_quiet", {aw_valid, w_valid, ar_valid, done_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
